// File: rtl/mem_stage.sv
// Memory stage: forwards ALU results to writeback and runs a single-outstanding,
// variable-latency load/store handshake with timeout, alignment check and HALT.
module mem_stage #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [4:0]  OP_ST   = 5'd8,
    parameter logic [4:0]  OP_LD   = 5'd9,
    parameter logic [4:0]  OP_STU  = 5'd10,
    parameter logic [4:0]  OP_HALT = 5'd29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_op,
    input  logic [15:0] ex_alu_out,
    input  logic [15:0] ex_st_data,
    input  logic        ex_wb_we,
    input  logic [2:0]  ex_wb_reg,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [2:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        err,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // Abort fires on the edge that closes the TIMEOUT-th waiting cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  op_q, op_d;
    logic [2:0]  reg_q, reg_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_wr_q, mem_wr_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [2:0]  wb_reg_q, wb_reg_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;
    logic        halted_q, halted_d;
    logic        is_mem_s;

    assign is_mem_s = (ex_op == OP_LD) || (ex_op == OP_ST) || (ex_op == OP_STU);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        reg_d       = reg_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we_q;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
        halted_d    = halted_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (ex_op == OP_HALT) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_reg_d   = ex_wb_reg;
                        wb_data_d  = ex_alu_out;
                        halted_d   = 1'b1;
                        state_d    = S_HALTED;
                    end else if (is_mem_s) begin
                        if (ex_alu_out[0]) begin
                            wb_valid_d = 1'b1;
                            wb_we_d    = 1'b0;
                            wb_reg_d   = ex_wb_reg;
                            wb_data_d  = ex_alu_out;
                            err_d      = 1'b1;
                        end else begin
                            op_d        = ex_op;
                            reg_d       = ex_wb_reg;
                            mem_addr_d  = ex_alu_out;
                            mem_wdata_d = ex_st_data;
                            mem_en_d    = 1'b1;
                            mem_wr_d    = (ex_op != OP_LD);
                            cnt_d       = 8'd0;
                            state_d     = S_ACCESS;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = ex_wb_we;
                        wb_reg_d   = ex_wb_reg;
                        wb_data_d  = ex_alu_out;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (mem_done) begin
                    mem_en_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_reg_d   = reg_q;
                    wb_we_d    = (op_q != OP_ST);
                    wb_data_d  = (op_q == OP_LD) ? mem_rdata : mem_addr_q;
                    cnt_d      = 8'd0;
                    state_d    = S_IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    mem_en_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b0;
                    wb_reg_d   = reg_q;
                    wb_data_d  = mem_addr_q;
                    err_d      = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HALTED: begin
                mem_en_d = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                mem_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= 5'd0;
            reg_q       <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'd0;
            mem_wdata_q <= 16'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_reg_q    <= 3'd0;
            wb_data_q   <= 16'd0;
            err_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            reg_q       <= reg_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
            halted_q    <= halted_d;
        end
    end

    assign ex_ready  = (state_q == S_IDLE);
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;
    assign halted    = halted_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the 16-bit ALU result and the 5-bit ALU opcode. Uses the result as the effective address for LD/ST/STU; passes every other result straight through to writeback.
- Runs a single-outstanding, variable-latency handshake to data memory and stalls execute while an access is in flight.
- Also detects unaligned accesses, memory timeouts and HALT.

Parameters:
- TIMEOUT, 15, max cycles in ACCESS waiting for mem_done before aborting (1..255).
- OP_ST, 8, opcode value for store.
- OP_LD, 9, opcode value for load.
- OP_STU, 10, opcode value for store-with-update.
- OP_HALT, 29, opcode value for halt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction this cycle.
- ex_ready  out  1  stage can accept; transfer occurs when ex_valid & ex_ready at a clk edge.
- ex_op  in  5  ALU opcode (ALU encoding).
- ex_alu_out  in  16  ALU result / effective address.
- ex_st_data  in  16  store data (Rd value).
- ex_wb_we  in  1  writeback enable for non-memory ops.
- ex_wb_reg  in  3  destination register.
- mem_en  out  1  memory request active.
- mem_wr  out  1  1=write, 0=read; valid when mem_en.
- mem_addr  out  16  word-aligned byte address.
- mem_wdata  out  16  store data.
- mem_done  in  1  memory completes the current request this cycle.
- mem_rdata  in  16  read data; valid when mem_done and read.
- wb_valid  out  1  one-cycle pulse: result for writeback.
- wb_we  out  1  register write enable; qualified by wb_valid.
- wb_reg  out  3  destination register.
- wb_data  out  16  writeback value.
- err  out  1  one-cycle pulse with wb_valid: unaligned access or timeout.
- halted  out  1  sticky; HALT has retired.

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, timeout counter 0.
  - ex_ready is combinational: 1 in IDLE only, so it reads 1 in the cycle after reset.
- States: IDLE, ACCESS, HALTED.
- IDLE, ex_ready=1:
  - On transfer of a non-memory, non-HALT op: the next cycle drives wb_valid=1, wb_data=ex_alu_out, wb_we=ex_wb_we, wb_reg=ex_wb_reg. State stays IDLE, so back-to-back throughput is 1/cycle.
  - On transfer of LD/ST/STU with ex_alu_out[0]=1: no memory request. The next cycle drives wb_valid=1, err=1, wb_we=0. State stays IDLE.
  - On transfer of an aligned LD/ST/STU: latch address, data, op and reg; go to ACCESS.
  - On transfer of HALT: the next cycle drives wb_valid=1, wb_we=0. Go to HALTED.
- ACCESS, ex_ready=0:
  - mem_en=1 for every cycle in ACCESS. mem_wr=1 for ST/STU. mem_addr and mem_wdata hold the latched values.
  - Counter increments each ACCESS cycle without mem_done.
  - On mem_done, in the next cycle: mem_en=0, wb_valid=1, go to IDLE. Writeback values:
    - LD: wb_data=mem_rdata, wb_we=1.
    - STU: wb_data=address, wb_we=1.
    - ST: wb_data=address, wb_we=0.
  - Minimum memory-op latency: accept at edge N, mem_en high in cycle N..N+1, mem_done in that cycle, wb_valid in the following cycle. In other words, wb_valid asserts 2 cycles after accept.
  - If the counter reaches TIMEOUT with no mem_done: mem_en drops, wb_valid=1, err=1, wb_we=0, go to IDLE, counter cleared.
  - mem_done together with the TIMEOUT boundary: mem_done wins and no err is raised.
  - mem_done outside ACCESS is ignored.
- HALTED: ex_ready=0, mem_en=0, halted=1 until rst.
- wb_valid and err are single-cycle pulses; wb_data/wb_reg hold their last values otherwise.
- rst asserted mid-ACCESS: at that edge go to IDLE, mem_en=0 in the next cycle, no wb_valid pulse, and the pending request is discarded.
- Ops other than LD/ST/STU/HALT are never treated as memory ops (ALU codes 0-31 are all legal inputs).

Test Plan:
- ADD result 0x1234, wb_we=1, reg 3, then SUB 0xFFFF next cycle -> wb_valid in two consecutive cycles with data 0x1234 then 0xFFFF; ex_ready stays 1.
- LD addr 0x0040, mem_done 3 cycles after mem_en rises, rdata 0xBEEF -> mem_en high 3 cycles, mem_wr=0, ex_ready low 3 cycles, then wb_valid=1, wb_we=1, wb_data=0xBEEF.
- ST addr 0x0010 data 0xA5A5 with same-cycle mem_done -> mem_wr=1, mem_wdata=0xA5A5, wb_valid 2 cycles after accept, wb_we=0. STU addr 0x0012 -> wb_we=1, wb_data=0x0012.
- LD addr 0x0041 -> mem_en never rises; next cycle wb_valid=1, err=1, wb_we=0.
- ST with mem_done never asserted, TIMEOUT=15 -> mem_en high exactly 15 cycles, then err pulse, IDLE. Repeat with mem_done on cycle 15 -> no err.
- HALT accepted -> halted=1, ex_ready=0 while ex_valid is held high. rst pulse during an LD ACCESS -> mem_en=0 next cycle, no wb_valid, ex_ready=1 after reset.
